// File: rtl/cordic_ci_issuer.sv
// Issues IEEE-754 angle words one at a time to a CORDIC custom-instruction slave
// and queues each result (or a quiet NaN on timeout) in a small result FIFO.
module cordic_ci_issuer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OUT_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        pause,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(OUT_DEPTH);
  localparam int CW     = AW + 1;
  localparam int CNT_W  = 10;
  localparam logic [CNT_W-1:0]  WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]     FIFO_FULL  = CW'(OUT_DEPTH);
  localparam logic [DATA_W-1:0] QNAN       = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0] fifo_mem_q [OUT_DEPTH];
  logic [DATA_W-1:0] fifo_mem_d [OUT_DEPTH];

  logic              push, pop, err_set;
  logic [DATA_W-1:0] push_data;

  // in_ready also drops during reset so nothing is accepted while rst is high.
  assign ci_clk_en   = ~pause;
  assign in_ready    = ~rst & (state_q == S_IDLE) & ~pause & (fifo_cnt_q != FIFO_FULL);
  assign ci_start    = (state_q == S_ISSUE) & ~pause;
  assign ci_dataa    = operand_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;
  assign out_valid   = (fifo_cnt_q != '0);
  assign out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign pop         = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    wait_cnt_d = wait_cnt_q;
    push       = 1'b0;
    push_data  = ci_result;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          operand_d = in_data;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!pause) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion on the limit cycle takes priority over the timeout.
        if (!pause) begin
          if (ci_done) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            push      = 1'b1;
            push_data = QNAN;
            err_set   = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      operand_q  <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage is data only; emptiness is tracked by fifo_cnt_q.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end
endmodule

// File: tb/tb_cordic_ci_issuer.sv
// Randomized and directed bench for cordic_ci_issuer against a transaction-level
// model: an op queue, a delay-driven slave and an expected-result FIFO.
module tb_cordic_ci_issuer;
  localparam int TO    = 64;
  localparam int DEPTH = 4;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, pause = 1'b0, out_ready = 1'b0, err_clr = 1'b0, ci_done = 1'b0;
  logic [31:0] in_data = '0, ci_result = '0;
  logic in_ready, ci_clk_en, ci_start, out_valid, busy, timeout_err;
  logic [31:0] ci_dataa, out_data;

  always #5 clk = ~clk;

  cordic_ci_issuer #(.TIMEOUT_CYCLES(TO), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pause(pause), .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
    .ci_result(ci_result), .ci_done(ci_done), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q[$];
  bit m_inflight, m_need_start, m_err;
  logic [31:0] m_operand;
  int m_wait_k;
  bit s_pending;
  int s_rem;
  logic [31:0] s_x;
  // Stimulus knobs
  bit k_pause, k_in_valid, k_out_ready, k_err_clr, k_force_done, k_spur;
  logic [31:0] k_in_data;
  int k_delay;
  int start_cnt = 0, accept_cnt = 0;

  function automatic logic [31:0] slave_f(input logic [31:0] x);
    return (x == 32'h3F7CAC08) ? 32'h3F0A8B7D : ({x[15:0], x[31:16]} ^ 32'h1234ABCD);
  endfunction

  task automatic idle_knobs();
    k_pause = 0; k_in_valid = 0; k_out_ready = 1; k_err_clr = 0; k_force_done = 0;
    k_spur = 0; k_in_data = '0; k_delay = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inflight = 0; m_need_start = 0; m_err = 0; m_operand = '0; m_wait_k = 0;
    s_pending = 0; s_rem = 0; s_x = '0;
  endtask

  task automatic do_reset(input bit p);
    @(negedge clk);
    rst = 1; pause = p; in_valid = 1; ci_done = 0; err_clr = 0; out_ready = 0;
    #2;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_ci_clk_en", ci_clk_en, !p);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ci_start", ci_start, 0);
    check_eq("rst_ci_dataa", ci_dataa, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    pause = !p;
    #1;
    check_eq("rst_ci_clk_en2", ci_clk_en, p);
    model_reset();
    @(negedge clk);
    rst = 0; in_valid = 0; pause = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check combinational
  // outputs, then advance the model by the effect of the coming rising edge.
  task automatic step();
    bit exp_ready, exp_start, push, set_err;
    logic [31:0] pdata;
    @(negedge clk);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    check_eq("busy", busy, m_inflight);
    check_eq("timeout_err", timeout_err, m_err);
    if (m_inflight) check_eq("ci_dataa", ci_dataa, m_operand);
    pause = k_pause; in_valid = k_in_valid; in_data = k_in_data;
    out_ready = k_out_ready; err_clr = k_err_clr;
    ci_done = 0; ci_result = $urandom;
    if (s_pending) begin
      if (!k_pause && s_rem == 1) begin
        ci_done = 1; ci_result = slave_f(s_x);
      end
    end else if (k_force_done || (k_spur && $urandom_range(0, 9) == 0)) begin
      ci_done = 1;
    end
    #1;
    exp_ready = !m_inflight && !k_pause && (exp_q.size() < DEPTH);
    exp_start = m_need_start && !k_pause;
    check_eq("ci_clk_en", ci_clk_en, !k_pause);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("ci_start", ci_start, exp_start);
    if (ci_start) start_cnt++;
    push = 0; set_err = 0; pdata = '0;
    if (m_inflight && !m_need_start && !k_pause) begin
      m_wait_k++;
      if (ci_done) begin
        push = 1; pdata = ci_result;
      end else if (m_wait_k == TO) begin
        push = 1; pdata = NAN; set_err = 1;
      end
      if (push) begin
        m_inflight = 0; s_pending = 0;
      end
    end
    if (s_pending && !k_pause && s_rem > 0) s_rem--;
    if (exp_start) begin
      m_need_start = 0; m_wait_k = 0; s_pending = 1; s_x = m_operand;
      s_rem = (k_delay > 0) ? k_delay : int'($urandom_range(1, TO + 8));
    end
    if (k_in_valid && exp_ready) begin
      m_inflight = 1; m_need_start = 1; m_operand = k_in_data; accept_cnt++;
    end
    m_err = set_err || (m_err && !k_err_clr);
    if (k_out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (push) exp_q.push_back(pdata);
  endtask

  logic [31:0] vals [5];
  int base, s0;

  initial begin
    model_reset();
    idle_knobs();
    do_reset(1'b1);

    // Single operation, slave answers 17 cycles after start
    idle_knobs(); k_out_ready = 0; k_delay = 17;
    k_in_valid = 1; k_in_data = 32'h3F7CAC08; s0 = start_cnt;
    step();
    k_in_valid = 0;
    repeat (25) step();
    check_eq("single_start", start_cnt - s0, 1);
    check_eq("single_result", out_data, 32'h3F0A8B7D);
    check_eq("single_not_busy", busy, 0);
    k_out_ready = 1;
    repeat (2) step();

    // Slave never completes: quiet NaN after TO wait cycles, sticky error
    idle_knobs(); k_out_ready = 0; k_delay = 1000;
    k_in_valid = 1; k_in_data = 32'h40490FDB;
    step();
    k_in_valid = 0;
    repeat (TO + 4) step();
    check_eq("to_err", timeout_err, 1);
    check_eq("to_nan", out_data, NAN);
    k_err_clr = 1; step();
    k_err_clr = 0; step();
    check_eq("to_err_clr", timeout_err, 0);
    k_out_ready = 1;
    repeat (2) step();

    // Five back-to-back angles with the consumer stalled
    idle_knobs(); k_out_ready = 0; k_delay = 3;
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    base = accept_cnt;
    k_in_valid = 1;
    repeat (40) begin
      k_in_data = vals[(accept_cnt - base < 5) ? (accept_cnt - base) : 4];
      step();
    end
    check_eq("b2b_accepted4", accept_cnt - base, 4);
    check_eq("b2b_in_ready", in_ready, 0);
    k_in_data = vals[4];
    k_out_ready = 1; step();
    k_out_ready = 0; step();
    check_eq("b2b_accepted5", accept_cnt - base, 5);
    k_in_valid = 0; k_out_ready = 1;
    repeat (15) step();

    // Pause for 5 cycles while waiting for the slave
    idle_knobs(); k_delay = 10;
    k_in_valid = 1; k_in_data = 32'h3E4CCCCD;
    step();
    k_in_valid = 0;
    repeat (3) step();
    k_pause = 1; repeat (5) step();
    k_pause = 0; repeat (20) step();
    check_eq("pause_no_to", timeout_err, 0);

    // Pause on the issue cycle defers the start strobe
    idle_knobs(); k_delay = 4;
    k_in_valid = 1; k_in_data = 32'h3F000000;
    step();
    k_in_valid = 0; k_pause = 1; s0 = start_cnt;
    repeat (3) step();
    check_eq("pstart_none", start_cnt - s0, 0);
    k_pause = 0;
    repeat (20) step();
    check_eq("pstart_one", start_cnt - s0, 1);

    // Reset mid-wait, then a stale completion
    idle_knobs(); k_out_ready = 0; k_delay = 20;
    k_in_valid = 1; k_in_data = 32'h3DCCCCCD;
    step();
    k_in_valid = 0;
    repeat (6) step();
    do_reset(1'b0);
    k_force_done = 1; repeat (3) step();
    k_force_done = 0; repeat (3) step();
    check_eq("stale_empty", out_valid, 0);
    check_eq("stale_idle", busy, 0);

    // Randomized traffic
    idle_knobs(); k_spur = 1;
    repeat (3000) begin
      k_pause     = ($urandom_range(0, 7) == 0);
      k_in_valid  = $urandom_range(0, 1);
      k_in_data   = $urandom;
      k_out_ready = ($urandom_range(0, 3) != 0);
      k_err_clr   = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_ci_issuer.md
CORDIC_CI_ISSUER -- requirements
Module: cordic_ci_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning max WAIT cycles allowed for ci_done after ci_start; legal range 2..1023.
REQ-002 Parameter OUT_DEPTH, default 4, meaning result FIFO entries; power of two, 2..16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1  host presents an angle word on in_data.
REQ-006 in_data  in  32  IEEE-754 single angle.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 pause  in  1  freezes the custom-instruction slave and the issuer FSM.
REQ-009 ci_clk_en  out  1  clock enable to the CORDIC custom-instruction slave.
REQ-010 ci_start  out  1  one-cycle start strobe to the slave.
REQ-011 ci_dataa  out  32  operand to the slave.
REQ-012 ci_result  in  32  slave result; valid only while ci_done=1.
REQ-013 ci_done  in  1  slave completion strobe.
REQ-014 out_valid  out  1  result FIFO non-empty.
REQ-015 out_data  out  32  FIFO head word.
REQ-016 out_ready  in  1  consumer pops head when out_valid=1.
REQ-017 busy  out  1  FSM not in IDLE.
REQ-018 timeout_err  out  1  sticky timeout flag.
REQ-019 err_clr  in  1  clears timeout_err.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT; one operation in flight at most.
REQ-021 in_ready SHALL be 1 iff state=IDLE, pause=0, FIFO count < OUT_DEPTH (combinational).
REQ-022 in_valid & in_ready: in_data latched into operand register, next state ISSUE.
REQ-023 ISSUE: ci_start=1 for exactly that one cycle, ci_dataa=operand register, wait counter cleared to 0, next state WAIT.
REQ-024 ci_dataa SHALL hold the operand register from ISSUE until the operation leaves WAIT.
REQ-025 WAIT: ci_done=1 pushes ci_result into FIFO, next state IDLE; earliest result push is 2 cycles after acceptance.
REQ-026 WAIT without ci_done: counter increments; when counter = TIMEOUT_CYCLES-1 and ci_done=0, push 32'h7FC00000 (quiet NaN), set timeout_err, next state IDLE.
REQ-027 ci_done in the same cycle as the timeout limit SHALL win: real result pushed, no error.
REQ-028 ci_done in IDLE or ISSUE SHALL be ignored.
REQ-029 ci_clk_en = ~pause; while pause=1 the FSM, wait counter and ci_start SHALL hold (ci_start forced 0), ci_done ignored; FIFO pops continue.
REQ-030 pause rising during ISSUE: ci_start suppressed and re-asserted for one cycle on the first cycle pause=0.
REQ-031 FIFO: out_valid = (count != 0); out_valid & out_ready pops head; push and pop same cycle leaves count unchanged, order preserved.
REQ-032 Push is always accepted (space reserved by REQ-021); pop when empty has no effect.
REQ-033 Pointers wrap modulo OUT_DEPTH; count width log2(OUT_DEPTH)+1.
REQ-034 err_clr clears timeout_err; simultaneous set and err_clr SHALL leave timeout_err=1.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 rst=1 asynchronously forces: state IDLE, ci_start 0, ci_dataa 0, operand 0, counter 0, FIFO empty (out_valid 0, out_data 0), timeout_err 0.
REQ-037 ci_clk_en follows ~pause during reset; in_ready 0 while rst=1.
REQ-038 Reset mid-WAIT abandons the operation; no push; later ci_done ignored until a new ISSUE.

Verification
REQ-039 in_data=32'h3F7CAC08 (0.987), slave done 17 cycles after start with 32'h3F0A8B7D -> one ci_start pulse, ci_dataa stable, out_data=32'h3F0A8B7D, out_valid next cycle, busy low.
REQ-040 Slave never asserts ci_done, TIMEOUT_CYCLES=64 -> push of 32'h7FC00000 exactly 64 WAIT cycles after ISSUE, timeout_err=1 until err_clr.
REQ-041 out_ready=0, five back-to-back angles -> four results queued, in_ready=0 after fourth, fifth accepted the cycle after first pop; FIFO order preserved.
REQ-042 pause=1 for 5 cycles during WAIT, then ci_done -> ci_clk_en low 5 cycles, counter frozen, result pushed, no timeout.
REQ-043 pause asserted on ISSUE cycle -> no ci_start during pause, single ci_start on first unpaused cycle.
REQ-044 rst pulse mid-WAIT, then stale ci_done -> all outputs at reset values, FIFO empty, no push.
